// File: rtl/sa_pkg.sv
// sa_pkg: shared state type, default sizes and output narrowing for sa_tile_engine
//   SA_TILE_SAT_EN defined   : sat_narrow clamps to the signed D_W range
//   SA_TILE_SAT_EN undefined : sat_narrow keeps the low D_W bits (wrap)
package sa_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_OUT} state_t;
  localparam int SA_D_W = 16;
  localparam int SA_K_MAX = 64;
  localparam int SA_ROWS = 16;
  localparam int SA_COLS = 16;
  localparam int SA_ACC_W = 2 * SA_D_W + $clog2(SA_K_MAX);
  localparam int SA_FLUSH_LEN = SA_ROWS + SA_COLS - 1;
  localparam logic signed [SA_ACC_W-1:0] SAT_HI = SA_ACC_W'((1 <<< (SA_D_W - 1)) - 1);
  localparam logic signed [SA_ACC_W-1:0] SAT_LO = -SAT_HI - 1;
  // v is the accumulator already scaled back by FRAC
  function automatic logic [SA_D_W-1:0] sat_narrow(input logic signed [SA_ACC_W-1:0] v);
`ifdef SA_TILE_SAT_EN
    return v > SAT_HI ? SAT_HI[SA_D_W-1:0] : v < SAT_LO ? SAT_LO[SA_D_W-1:0] : v[SA_D_W-1:0];
`else
    return v[SA_D_W-1:0];
`endif
  endfunction
endpackage

// File: rtl/sa_tile_pe.sv
// sa_tile_pe: one systolic cell; registers x east / w south and accumulates x*w when enabled
//   I_CLK, I_ASYN_RSTN : clock, async active-low reset
//   clr_pipe / clr_acc : synchronous clear of pass-through regs / accumulator
//   en                 : array step enable
//   x_i, w_i -> x_o, w_o : operand pass-through, acc : running sum
module sa_tile_pe #(
  parameter int D_W = 16,
  parameter int ACC_W = 38
) (
  input  logic                    I_CLK,
  input  logic                    I_ASYN_RSTN,
  input  logic                    clr_pipe,
  input  logic                    clr_acc,
  input  logic                    en,
  input  logic signed [D_W-1:0]   x_i,
  input  logic signed [D_W-1:0]   w_i,
  output logic signed [D_W-1:0]   x_o,
  output logic signed [D_W-1:0]   w_o,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [2*D_W-1:0] prod;
  assign prod = x_i * w_i;
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
    if (!I_ASYN_RSTN) begin
      x_o <= '0;
      w_o <= '0;
    end else if (clr_pipe) begin
      x_o <= '0;
      w_o <= '0;
    end else if (en) begin
      x_o <= x_i;
      w_o <= w_i;
    end
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
    if (!I_ASYN_RSTN) acc <= '0;
    else if (clr_acc) acc <= '0;
    else if (en) acc <= acc + ACC_W'(prod);
endmodule

// File: rtl/sa_tile_engine.sv
// sa_tile_engine: streaming systolic matmul OUT[SA_R][SA_C] = X[SA_R][K] * W[K][SA_C], runtime K
//   I_CLK, I_ASYN_RSTN (async, low), I_SYNC_RSTN (sync, low)
//   I_START, I_K_LEN, I_ACC_MODE : pass control, sampled in S_IDLE
//   I_VLD/O_RDY, I_X_VEC, I_W_VEC : one K-step per beat
//   O_ROW_VLD/I_ROW_RDY, O_ROW_IDX, O_ROW : result rows 0..SA_R-1
//   O_BUSY, O_DONE : activity and end-of-pass pulse
//   SA_TILE_SAT_EN selects saturating (defined) or wrapping (undefined) output narrowing
module sa_tile_engine import sa_pkg::*; #(
  parameter int D_W = SA_D_W,
  parameter int FRAC = 13,
  parameter int SA_R = SA_ROWS,
  parameter int SA_C = SA_COLS,
  parameter int K_MAX = SA_K_MAX,
  parameter int ACC_W = 2 * D_W + $clog2(K_MAX)
) (
  input  logic                          I_CLK,
  input  logic                          I_ASYN_RSTN,
  input  logic                          I_SYNC_RSTN,
  input  logic                          I_START,
  input  logic [$clog2(K_MAX+1)-1:0]    I_K_LEN,
  input  logic                          I_ACC_MODE,
  input  logic                          I_VLD,
  output logic                          O_RDY,
  input  logic [SA_R-1:0][D_W-1:0]      I_X_VEC,
  input  logic [SA_C-1:0][D_W-1:0]      I_W_VEC,
  output logic                          O_ROW_VLD,
  input  logic                          I_ROW_RDY,
  output logic [$clog2(SA_R)-1:0]       O_ROW_IDX,
  output logic [SA_C-1:0][D_W-1:0]      O_ROW,
  output logic                          O_BUSY,
  output logic                          O_DONE
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int FLUSH_LEN = SA_R + SA_C - 1;
  localparam int CW = $clog2(K_MAX + FLUSH_LEN + 1);
  localparam int RW = $clog2(SA_R);
  state_t state, state_n;
  logic [KW-1:0] k_q;
  logic [CW-1:0] cnt;
  logic start, step, srst, clr_pipe, clr_acc, row_fire, row_last;
  logic signed [D_W-1:0] x_sk [SA_R];
  logic signed [D_W-1:0] w_sk [SA_C];
  logic signed [D_W-1:0] xo [SA_R][SA_C];
  logic signed [D_W-1:0] wo [SA_R][SA_C];
  logic signed [ACC_W-1:0] acc [SA_R][SA_C];
  assign srst = !I_SYNC_RSTN;
  assign start = state == S_IDLE && I_START;
  // the array only moves on accepted beats or while draining, so input bubbles freeze it
  assign step = (state == S_LOAD && I_VLD) || state == S_FLUSH;
  assign clr_pipe = srst || start;
  assign clr_acc = srst || (start && !I_ACC_MODE);
  assign O_RDY = state == S_LOAD;
  assign O_ROW_VLD = state == S_OUT;
  assign O_BUSY = state != S_IDLE;
  assign row_fire = O_ROW_VLD && I_ROW_RDY;
  assign row_last = O_ROW_IDX == RW'(SA_R - 1);
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = I_K_LEN == '0 ? S_OUT : S_LOAD;
      S_LOAD:  if (I_VLD && cnt == CW'(k_q - 1'b1)) state_n = S_FLUSH;
      S_FLUSH: if (cnt == CW'(FLUSH_LEN - 1)) state_n = S_OUT;
      S_OUT:   if (row_fire && row_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  // cnt counts accepted beats in S_LOAD and drain cycles in S_FLUSH; it restarts on every state change
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
    if (!I_ASYN_RSTN) begin
      state <= S_IDLE;
      k_q <= '0;
      cnt <= '0;
      O_ROW_IDX <= '0;
      O_DONE <= 1'b0;
    end else if (srst) begin
      state <= S_IDLE;
      k_q <= '0;
      cnt <= '0;
      O_ROW_IDX <= '0;
      O_DONE <= 1'b0;
    end else begin
      state <= state_n;
      if (start) k_q <= I_K_LEN;
      cnt <= state_n != state ? '0 : cnt + CW'(step);
      O_ROW_IDX <= !row_fire ? O_ROW_IDX : row_last ? '0 : O_ROW_IDX + 1'b1;
      O_DONE <= row_fire && row_last;
    end
  // input skew: row r of x and column c of w are delayed r / c steps; zeros feed in outside S_LOAD
  for (genvar r = 0; r < SA_R; r++) begin : g_xs
    logic [D_W-1:0] x_in;
    assign x_in = O_RDY ? I_X_VEC[r] : '0;
    if (r == 0) begin : g_d
      assign x_sk[r] = x_in;
    end else begin : g_d
      logic [r*D_W-1:0] q;
      always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
        if (!I_ASYN_RSTN) q <= '0;
        else if (clr_pipe) q <= '0;
        else if (step) q <= (r*D_W)'({q, x_in});
      assign x_sk[r] = q[r*D_W-1 -: D_W];
    end
  end
  for (genvar c = 0; c < SA_C; c++) begin : g_ws
    logic [D_W-1:0] w_in;
    assign w_in = O_RDY ? I_W_VEC[c] : '0;
    if (c == 0) begin : g_d
      assign w_sk[c] = w_in;
    end else begin : g_d
      logic [c*D_W-1:0] q;
      always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
        if (!I_ASYN_RSTN) q <= '0;
        else if (clr_pipe) q <= '0;
        else if (step) q <= (c*D_W)'({q, w_in});
      assign w_sk[c] = q[c*D_W-1 -: D_W];
    end
  end
  for (genvar r = 0; r < SA_R; r++) begin : g_r
    for (genvar c = 0; c < SA_C; c++) begin : g_c
      logic signed [D_W-1:0] xi, wi;
      if (c == 0) begin : g_xi
        assign xi = x_sk[r];
      end else begin : g_xi
        assign xi = xo[r][c-1];
      end
      if (r == 0) begin : g_wi
        assign wi = w_sk[c];
      end else begin : g_wi
        assign wi = wo[r-1][c];
      end
      sa_tile_pe #(.D_W(D_W), .ACC_W(ACC_W)) u_pe (
        .I_CLK(I_CLK), .I_ASYN_RSTN(I_ASYN_RSTN), .clr_pipe(clr_pipe), .clr_acc(clr_acc),
        .en(step), .x_i(xi), .w_i(wi), .x_o(xo[r][c]), .w_o(wo[r][c]), .acc(acc[r][c])
      );
    end
  end
  for (genvar c = 0; c < SA_C; c++) begin : g_o
    assign O_ROW[c] = sat_narrow(SA_ACC_W'(acc[O_ROW_IDX][c] >>> FRAC));
  end
endmodule
